// File: rtl/quant_block_pkg.sv
// quant_block_pkg: shared types and constants for the forward quantizer.
//   CH                : number of colour channels (overridable define)
//   quant_table_t     : one 8x8 table of unsigned Q_W-bit divisors
//   quant_packet_t    : all tables plus the channel-to-table map
//   quant_state_e     : IDLE / RUN / DONE
//   QUANT_DIV_CYCLES  : cycles spent on each coefficient division
`ifndef CH
`define CH 2
`endif

package quant_block_pkg;

  localparam int CH_N  = `CH;
  localparam int CH_W  = $clog2(CH_N + 1);
  localparam int MAP_N = 1 << CH_W;  // every encodable ch value has a map slot
  localparam int PKG_Q_W = 8;
  localparam int NTABS = 2;
  localparam int TAB_W = 1;

  localparam int QUANT_DIV_CYCLES = 12;

  typedef logic [7:0][7:0][PKG_Q_W-1:0] quant_table_t;

  typedef struct packed {
    quant_table_t [NTABS-1:0]   tabs;
    logic [MAP_N-1:0][TAB_W-1:0] map;
  } quant_packet_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } quant_state_e;

endpackage

// File: rtl/quant_div_serial.sv
// quant_div_serial: serial restoring divider, one quotient bit per cycle.
//   start     : load dividend/divisor and resolve the top quotient bit now
//   dividend  : N_W-bit unsigned numerator
//   divisor   : D_W-bit unsigned denominator (0 yields all-ones quotient)
//   quotient  : N_W-1 bit result, valid while done is high
//   done      : high on the QUANT_DIV_CYCLES-th cycle counted from start
// The dividend is below 2^(N_W-1), so the first step compares against
// divisor<<(N_W-2) directly instead of spending a cycle on the MSB.
module quant_div_serial
  import quant_block_pkg::*;
#(
  parameter int N_W = 13,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [N_W-2:0] quotient,
  output logic           done
);

  localparam int X_W = 2 * N_W + D_W;

  logic [N_W-1:0] rem_r, rem_cur_s, rem_next_s;
  logic [N_W-2:0] quot_r, quot_cur_s, quot_next_s;
  logic [3:0]     cnt_r, cnt_cur_s, bit_s;
  logic           busy_r;
  logic [X_W-1:0] sub_s;
  logic           ge_s;

  // One restoring step: compare the partial remainder with the shifted divisor.
  always_comb begin
    rem_cur_s   = rem_r;
    quot_cur_s  = quot_r;
    cnt_cur_s   = cnt_r;
    if (start) begin
      rem_cur_s  = dividend;
      quot_cur_s = '0;
      cnt_cur_s  = 4'd0;
    end else begin
      rem_cur_s  = rem_r;
    end
    bit_s       = 4'(QUANT_DIV_CYCLES - 1) - cnt_cur_s;
    sub_s       = X_W'(divisor) << bit_s;
    ge_s        = (X_W'(rem_cur_s) >= sub_s);
    rem_next_s  = rem_cur_s;
    quot_next_s = quot_cur_s;
    if (ge_s) begin
      rem_next_s  = rem_cur_s - sub_s[N_W-1:0];
      quot_next_s = quot_cur_s | ({{(N_W-2){1'b0}}, 1'b1} << bit_s);
    end else begin
      rem_next_s  = rem_cur_s;
    end
  end

  // The last bit is resolved in the done cycle, so expose it combinationally.
  assign quotient = quot_next_s;
  assign done     = busy_r && (cnt_r == 4'(QUANT_DIV_CYCLES - 1));

  // Step counter and partial remainder/quotient registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r  <= '0;
      quot_r <= '0;
      cnt_r  <= 4'd0;
      busy_r <= 1'b0;
    end else if (start) begin
      rem_r  <= rem_next_s;
      quot_r <= quot_next_s;
      cnt_r  <= 4'd1;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r  <= rem_next_s;
      quot_r <= quot_next_s;
      if (done) begin
        cnt_r  <= 4'd0;
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + 4'd1;
      end
    end
  end

endmodule

// File: rtl/quant_block.sv
// quant_block: forward JPEG quantizer, 8x8 block / per-channel table,
// rounding half away from zero, one shared serial divider.
//   clk, rst_n           : clock, synchronous active-low reset
//   blockIn/ch/quant_packet, valid_in, ready_out : input handshake
//   blockOut/chOut, valid_out, ready_in           : output handshake
//   nzCount              : nonzero results of the block (QUANT_NZ_COUNT_EN)
// Optional feature macro: QUANT_NZ_COUNT_EN.
module quant_block
  import quant_block_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int Q_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0][7:0][COEF_W-1:0]   blockIn,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic [CH_W-1:0]               ch,
  input  quant_packet_t                 quant_packet,
  output logic [7:0][7:0][COEF_W-1:0]   blockOut,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [CH_W-1:0]               chOut
`ifdef QUANT_NZ_COUNT_EN
  ,
  output logic [6:0]                    nzCount
`endif
);

  quant_state_e state_r, state_s;

  logic [7:0][7:0][COEF_W-1:0] block_r;
  quant_table_t                table_r;
  logic [5:0]                  idx_r;
  logic                        start_pend_r;
  logic                        ready_r, valid_r;

  logic [COEF_W-1:0] x_s, a_s, res_s;
  logic [Q_W-1:0]    q_s;
  logic              neg_s;
  logic [COEF_W:0]   n_s;
  logic [COEF_W-1:0] quot_s;
  logic              div_done_s, accept_s, wr_s;

  assign ready_out = ready_r;
  assign valid_out = valid_r;
  assign accept_s  = valid_in && ready_r && (state_r == IDLE);
  assign wr_s      = (state_r == RUN) && div_done_s;

  // Rounding numerator |x| + q/2 and sign restoration of the quotient.
  always_comb begin
    x_s   = block_r[idx_r[5:3]][idx_r[2:0]];
    q_s   = table_r[idx_r[5:3]][idx_r[2:0]];
    neg_s = x_s[COEF_W-1];
    // -2048 negates to 0x800, which reads correctly as unsigned 2048.
    a_s   = neg_s ? (~x_s + {{(COEF_W-1){1'b0}}, 1'b1}) : x_s;
    n_s   = {1'b0, a_s} + (COEF_W+1)'(q_s >> 1);
    if (q_s == '0) begin
      res_s = x_s;
    end else if (neg_s) begin
      res_s = ~quot_s + {{(COEF_W-1){1'b0}}, 1'b1};
    end else begin
      res_s = quot_s;
    end
  end

  quant_div_serial #(
    .N_W(COEF_W + 1),
    .D_W(Q_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_pend_r),
    .dividend (n_s),
    .divisor  (q_s),
    .quotient (quot_s),
    .done     (div_done_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (wr_s && (idx_r == 6'd63)) state_s = DONE;
        else                          state_s = RUN;
      end
      DONE: begin
        if (ready_in) state_s = IDLE;
        else          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, handshake flags, captured block and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ready_r      <= 1'b0;
      valid_r      <= 1'b0;
      block_r      <= '0;
      table_r      <= '0;
      idx_r        <= 6'd0;
      start_pend_r <= 1'b0;
      blockOut     <= '0;
      chOut        <= '0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      valid_r <= (state_s == DONE);
      if (accept_s) begin
        block_r      <= blockIn;
        table_r      <= quant_packet.tabs[quant_packet.map[ch]];
        chOut        <= ch;
        idx_r        <= 6'd0;
        start_pend_r <= 1'b1;
      end else if (state_r == RUN) begin
        // Kick the next division right after each write, except the last.
        start_pend_r <= wr_s && (idx_r != 6'd63);
        if (wr_s) begin
          blockOut[idx_r[5:3]][idx_r[2:0]] <= res_s;
          idx_r <= idx_r + 6'd1;
        end
      end
    end
  end

`ifdef QUANT_NZ_COUNT_EN
  // Count of nonzero results written for the current block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nzCount <= 7'd0;
    end else if (accept_s) begin
      nzCount <= 7'd0;
    end else if (wr_s && (res_s != '0)) begin
      nzCount <= nzCount + 7'd1;
    end
  end
`endif

endmodule
